// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed N-tap FIR, one multiplier and one accumulator, valid/ready streams
// FIR_SERIAL_SAT_EN: saturate the result to W bits and raise sticky ovf; otherwise wrap and tie ovf low
module fir_serial_mac #(
    parameter int W      = 16,
    parameter int W_FRAC = 15,
    parameter int N      = 41
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [W-1:0]  x_data,
    input  logic                 x_valid,
    output logic                 x_ready,
    output logic signed [W-1:0]  y_data,
    output logic                 y_valid,
    input  logic                 y_ready,
    input  logic                 coef_we,
    input  logic [$clog2(N)-1:0] coef_addr,
    input  logic signed [W-1:0]  coef_wdata,
    output logic                 coef_ready,
    output logic                 ovf
);
    localparam int AW    = $clog2(N);
    localparam int KW    = $clog2(N + 1);
    localparam int ACC_W = 2 * W + AW + 1;
    localparam logic signed [ACC_W-1:0] RND =
        (W_FRAC > 0) ? ACC_W'(1) << (W_FRAC > 0 ? W_FRAC - 1 : 0) : '0;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state, state_nx;
    logic signed [W-1:0]      smp  [N];
    logic signed [W-1:0]      coef [N];
    logic [AW-1:0]            wr_ptr, idx, kt;
    logic [KW-1:0]            k;
    logic signed [2*W-1:0]    prod;
    logic signed [ACC_W-1:0]  acc, sum;
    logic signed [W-1:0]      res;
    logic                     take, wr, last;

    // Products are registered, so k runs one past N-1 to fold in the last product
    always_comb begin
        x_ready    = state == IDLE;
        coef_ready = state == IDLE;
        y_valid    = state == OUT;
        take       = x_valid && x_ready;
        wr         = coef_we && coef_ready && ({1'b0, coef_addr} < (AW + 1)'(N));
        last       = k == KW'(N);
        kt         = last ? '0 : AW'(k);
        idx        = (KW'(wr_ptr) >= k) ? AW'(KW'(wr_ptr) - k)
                                        : AW'(KW'(wr_ptr) + (KW'(N) - k));
        sum        = acc + ACC_W'(prod) + RND;
        state_nx   = (state == IDLE && x_valid) ? MAC :
                     (state == MAC && last)     ? OUT :
                     (state == OUT && y_ready)  ? IDLE : state;
    end

`ifdef FIR_SERIAL_SAT_EN
    localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) << (W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MINV = -(ACC_W'(1) << (W - 1));
    logic signed [ACC_W-1:0] shifted;
    logic                    hi, lo;

    always_comb begin
        shifted = sum >>> W_FRAC;
        hi      = shifted > MAXV;
        lo      = shifted < MINV;
        res     = hi ? MAXV[W-1:0] : lo ? MINV[W-1:0] : shifted[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else if (state == MAC && last && (hi || lo)) ovf <= 1'b1;
    end
`else
    always_comb res = W'(sum >>> W_FRAC);
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                smp[i]  <= '0;
                coef[i] <= '0;
            end
            wr_ptr <= '0;
            k      <= '0;
            acc    <= '0;
            prod   <= '0;
            y_data <= '0;
        end else begin
            if (wr) coef[coef_addr] <= coef_wdata;
            if (take) begin
                smp[wr_ptr] <= x_data;
                acc         <= '0;
                prod        <= '0;
                k           <= '0;
            end
            if (state == MAC) begin
                prod <= smp[idx] * coef[kt];
                acc  <= acc + ACC_W'(prod);
                k    <= k + 1'b1;
                if (last) begin
                    y_data <= res;
                    wr_ptr <= (wr_ptr == AW'(N - 1)) ? '0 : wr_ptr + 1'b1;
                end
            end
        end
    end
endmodule
